// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the small decode helpers used by both the control and datapath blocks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_e;

  // Access size in bytes; only the low two funct3 bits carry the width.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic load, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return load;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment datapath: store mask/data placement across two words and
// load extraction with sign or zero extension from the {hi,lo} word pair.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [7:0]  bmask8,
  output logic [63:0] data64,
  output logic [31:0] rdata
);

  logic [2:0]  size;
  logic [7:0]  size_mask;
  logic [31:0] shifted;

  assign size      = access_size(funct3);
  assign size_mask = (8'd1 << size) - 8'd1;
  assign bmask8    = size_mask << off;
  assign data64    = {32'd0, wdata} << {off, 3'b000};
  assign shifted   = 32'({hi_word, lo_word} >> {off, 3'b000});

  always_comb begin
    // NOTE: rdata is assigned before the case so every path drives it and no latch is inferred.
    rdata = shifted;
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata = {24'd0, shifted[7:0]};
      F3_HU:   rdata = {16'd0, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store stage: one request at a time, word-crossing accesses
// split into two word accesses, single-cycle response pulse to writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_load_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic [31:0] DMemRAddr_o,
  input  logic [31:0] DMemRData_i,
  output logic [31:0] DMemWAddr_o,
  output logic [31:0] DMemWData_o,
  output logic [3:0]  DMemWMask_o,
  output logic        rsp_valid_o,
  output logic        rsp_we_o,
  output logic [4:0]  rsp_rd_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o
);

  lsu_state_e  state, state_next;
  logic        load_q, err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, lo_q, hi_q;
  logic [4:0]  rd_q;

  logic        accept, req_misaligned, req_err, misaligned_q;
  logic [31:0] lo_addr;
  logic [7:0]  bmask8;
  logic [63:0] data64;
  logic [31:0] rdata;

  assign accept         = req_valid_i && (state == IDLE);
  assign req_misaligned = ({1'b0, req_addr_i[1:0]} + access_size(req_funct3_i)) > 3'd4;
  assign req_err        = !funct3_legal(req_load_i, req_funct3_i)
                        || (req_misaligned && !ALLOW_MISALIGNED);
  assign misaligned_q   = ({1'b0, addr_q[1:0]} + access_size(funct3_q)) > 3'd4;
  assign lo_addr        = {addr_q[31:2], 2'b00};
  assign req_ready_o    = (state == IDLE);

  lsu_align u_align (
    .funct3  (funct3_q),
    .off     (addr_q[1:0]),
    .wdata   (wdata_q),
    .lo_word (lo_q),
    .hi_word (hi_q),
    .bmask8  (bmask8),
    .data64  (data64),
    .rdata   (rdata)
  );

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_err ? RESP : ACC0;
      ACC0:    state_next = misaligned_q ? ACC1 : RESP;
      ACC1:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      if (accept) begin
        load_q   <= req_load_i;
        err_q    <= req_err;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
        rd_q     <= req_rd_i;
      end
      // Aligned loads never look at hi_q, so a stale value there is harmless.
      if (state == ACC0 && load_q) lo_q <= DMemRData_i;
      if (state == ACC1 && load_q) hi_q <= DMemRData_i;
    end
  end

  always_comb begin
    DMemRAddr_o = '0;
    DMemWAddr_o = '0;
    DMemWData_o = '0;
    DMemWMask_o = '0;
    rsp_valid_o = 1'b0;
    rsp_we_o    = 1'b0;
    rsp_rd_o    = '0;
    rsp_data_o  = '0;
    rsp_err_o   = 1'b0;
    case (state)
      ACC0: begin
        DMemRAddr_o = lo_addr;
        DMemWAddr_o = lo_addr;
        if (!load_q) begin
          DMemWMask_o = bmask8[3:0];
          DMemWData_o = data64[31:0];
        end
      end
      ACC1: begin
        DMemRAddr_o = lo_addr + 32'd4;
        DMemWAddr_o = lo_addr + 32'd4;
        if (!load_q) begin
          DMemWMask_o = bmask8[7:4];
          DMemWData_o = data64[63:32];
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rd_o    = rd_q;
        rsp_we_o    = load_q && !err_q;
        rsp_data_o  = (load_q && !err_q) ? rdata : 32'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-side access stage between the pipeline's execute/memory stage and the data memory. It accepts one load or store request at a time over a valid/ready handshake. For stores it generates the byte-lane write mask and lane-shifted write data; for loads it extracts, sign- or zero-extends and returns the addressed bytes. Misaligned accesses are split into two word accesses with a small FSM, and the result is returned to writeback as a one-cycle response pulse.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two word accesses; 0 = reject them with rsp_err_o and no memory write.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request present
req_ready_o  out  1  unit can accept; high only in IDLE
req_load_i  in  1  1 = load, 0 = store
req_funct3_i  in  3  RV32I width/sign code
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-justified
req_rd_i  in  5  load destination register tag
DMemRAddr_o  out  32  read byte address, always word-aligned
DMemRData_i  in  32  read word, combinational from memory
DMemWAddr_o  out  32  write byte address, always word-aligned
DMemWData_o  out  32  lane-positioned write data
DMemWMask_o  out  4  byte write enables; write commits at clock edge
rsp_valid_o  out  1  one-cycle completion pulse
rsp_we_o  out  1  1 = writeback rsp_data_o to rsp_rd_o (error-free loads only)
rsp_rd_o  out  5  tag echoed from request
rsp_data_o  out  32  extended load data; 0 for stores
rsp_err_o  out  1  illegal funct3, or misaligned access with ALLOW_MISALIGNED=0

Behaviour:
- Reset: state IDLE, req_ready_o=1, DMemWMask_o=0, rsp_valid_o=0, rsp_we_o=0, rsp_err_o=0, rsp_data_o=0, rsp_rd_o=0, addresses=0.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Size: 1, 2 or 4 bytes. off = addr[1:0]. Access is misaligned when off + size > 4.
- Request handshake: accept on req_valid_i & req_ready_o in cycle N. Latch request; state ACC0.
- Illegal or rejected request: no memory access, DMemWMask_o=0. Go directly to RESP: rsp_valid_o=1 and rsp_err_o=1 in cycle N+1.
- ACC0 (cycle N+1):
  - DMemRAddr_o = DMemWAddr_o = {addr[31:2],2'b00}.
  - bmask8 = ((1<<size)-1) << off; data64 = {32'b0,wdata} << (8*off).
  - Store: DMemWMask_o = bmask8[3:0], DMemWData_o = data64[31:0].
  - Load: latch DMemRData_i into lo word.
  - If not misaligned, go to RESP; else go to ACC1.
- ACC1 (cycle N+2):
  - Address is the lo address + 4, wrapping mod 2^32 (0xFFFFFFFC + 4 gives 0x0).
  - Store: DMemWMask_o = bmask8[7:4], DMemWData_o = data64[63:32].
  - Load: latch hi word.
- RESP (one cycle; N+2 aligned, N+3 split):
  - rsp_valid_o=1. Load data = ({hi,lo} >> 8*off), masked to size, then sign-extended (LB/LH) or zero-extended.
  - Stores: rsp_we_o=0. Then IDLE.
- DMemWMask_o is 0 in IDLE, RESP and for loads. No write ever occurs outside ACC0/ACC1.
- No response backpressure; response held exactly one cycle. Next request is accepted no earlier than the cycle after RESP.
- Reset mid-operation: next edge forces IDLE and all reset values. A pending ACC1 half is discarded (a split store may be left half-written). No response is issued.
- req inputs are ignored when req_ready_o=0.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum {IDLE, ACC0, ACC1, RESP}.
  - size-decode function.
- One combinational sub-module lsu_align:
  - Computes bmask8 and data64 from funct3/off/wdata.
  - Extracts and extends load data from {hi,lo}.
- load_store_unit holds the FSM and request/response registers.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF → N+1: DMemWAddr_o=0x100, mask 1111, WData 0xDEADBEEF; N+2: rsp_valid_o=1, rsp_we_o=0, err=0.
2. SB addr 0x103, data 0x123456A5 → N+1: mask 1000, WData 0xA5000000; no further write.
3. Word 0x100 = 0x80FF1234. LH 0x102, rd=5 → rsp_data_o=0xFFFF80FF, rsp_we_o=1, rsp_rd_o=5. LHU 0x102 → 0x000080FF. LB 0x101 → 0x00000012.
4. Misaligned LW 0x103 with mem[0x100]=0x44332211, mem[0x104]=0x88776655 → RAddr 0x100 at N+1, 0x104 at N+2, rsp at N+3 = 0x77665544. With ALLOW_MISALIGNED=0 → rsp_err_o=1 at N+1, no read latch.
5. Misaligned SH 0x107, data 0xBBAA → N+1: addr 0x104, mask 1000, WData 0xAA000000; N+2: addr 0x108, mask 0001, WData 0x000000BB. Same at 0xFFFFFFFF → second half to 0x00000000.
6. Store with funct3 011 → err at N+1, mask 0 throughout. Misaligned SW with rst_i high during ACC0 → cycle N+2: mask 0, rsp_valid_o=0, req_ready_o=1; only the lo half was written.
